// File: rtl/reg_file_sequencer.sv
// Command sequencer for the 8086 general-register file: reads two operands, runs an 8-bit ALU op,
// updates ZF/CF/SF and writes the result back, one command in flight at a time.
module reg_file_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              zf,
    output logic              cf,
    output logic              sf,
    output logic [ADDR_W-1:0] read_addr1,
    output logic [ADDR_W-1:0] read_addr2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [ADDR_W-1:0] read_addr3,
    input  logic [DATA_W-1:0] read_data3,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRead = 3'd1;
    localparam logic [2:0] StExec = 3'd2;
    localparam logic [2:0] StWb   = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam logic [2:0] OpMov = 3'b000;
    localparam logic [2:0] OpAdd = 3'b001;
    localparam logic [2:0] OpSub = 3'b010;
    localparam logic [2:0] OpAnd = 3'b011;
    localparam logic [2:0] OpOr  = 3'b100;
    localparam logic [2:0] OpXor = 3'b101;
    localparam logic [2:0] OpInc = 3'b110;
    localparam logic [2:0] OpCmp = 3'b111;

    logic [2:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zf_q, zf_d;
    logic              cf_q, cf_d;
    logic              sf_q, sf_d;
    logic              err_q, err_d;

    logic              accept;
    logic              addr_bad;
    logic [DATA_W-1:0] alu_res;
    logic              alu_zf, alu_cf, alu_sf;

    assign accept   = (state_q == StIdle) && cmd_valid;
    // Only AX..DX exist; any upper address bit set rejects the command.
    assign addr_bad = (|cmd_dst[ADDR_W-1:2]) || (|cmd_src[ADDR_W-1:2]);

    always_comb begin
        alu_res = result_q;
        alu_zf  = zf_q;
        alu_cf  = cf_q;
        alu_sf  = sf_q;
        unique case (op_q)
            OpMov:        alu_res = b_q;
            OpAdd:        {alu_cf, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OpSub, OpCmp: {alu_cf, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            OpAnd: begin
                alu_res = a_q & b_q;
                alu_cf  = 1'b0;
            end
            OpOr: begin
                alu_res = a_q | b_q;
                alu_cf  = 1'b0;
            end
            OpXor: begin
                alu_res = a_q ^ b_q;
                alu_cf  = 1'b0;
            end
            OpInc:        alu_res = a_q + DATA_W'(1);
            default:      alu_res = result_q;
        endcase
        if (op_q != OpMov) begin
            alu_zf = (alu_res == '0);
            alu_sf = alu_res[DATA_W-1];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        src_d    = src_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        sf_d     = sf_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    src_d   = cmd_src;
                    err_d   = addr_bad;
                    state_d = addr_bad ? StDone : StRead;
                end
            end
            StRead: begin
                a_d     = read_data1;
                b_d     = read_data2;
                state_d = StExec;
            end
            StExec: begin
                result_d = alu_res;
                zf_d     = alu_zf;
                cf_d     = alu_cf;
                sf_d     = alu_sf;
                state_d  = StWb;
            end
            StWb:    state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= OpMov;
            dst_q    <= '0;
            src_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            sf_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            sf_q     <= sf_d;
            err_q    <= err_d;
        end
    end

    // Write strobe decoded from state so an async reset kills it in the same instant.
    assign write_enable = (state_q == StWb) && (op_q != OpCmp);
    assign write_addr   = dst_q;
    assign write_data   = result_q;
    assign read_addr1   = dst_q;
    assign read_addr2   = src_q;
    assign cmd_ready    = (state_q == StIdle);
    assign done         = (state_q == StDone);
    assign err          = err_q;
    assign result       = result_q;
    assign zf           = zf_q;
    assign cf           = cf_q;
    assign sf           = sf_q;
    assign read_addr3   = dbg_addr;
    assign dbg_data     = read_data3;

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench for reg_file_sequencer: behavioural register file plus an arithmetic reference model of
// the ALU commands, directed scenarios followed by randomized commands.
module tb_reg_file_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [2:0] cmd_dst = 3'd0;
    logic [2:0] cmd_src = 3'd0;
    logic       done, err, zf, cf, sf, write_enable;
    logic [7:0] result, write_data, read_data1, read_data2, read_data3, dbg_data;
    logic [2:0] read_addr1, read_addr2, write_addr, read_addr3;
    logic [2:0] dbg_addr = 3'd0;

    // Register file and its preload port.
    logic [7:0] rf [0:7];
    logic       pre_we = 1'b0;
    logic [2:0] pre_addr = 3'd0;
    logic [7:0] pre_data = 8'd0;

    // Reference model state.
    logic [7:0] exp_rf [0:7];
    logic [7:0] m_result = 8'd0;
    logic       m_zf = 1'b0, m_cf = 1'b0, m_sf = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (write_enable) rf[write_addr] <= write_data;
    end
    assign read_data1 = rf[read_addr1];
    assign read_data2 = rf[read_addr2];
    assign read_data3 = rf[read_addr3];

    reg_file_sequencer #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src(cmd_src),
        .done(done), .err(err), .result(result), .zf(zf), .cf(cf), .sf(sf),
        .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(read_data1), .read_data2(read_data2),
        .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
        .dbg_addr(dbg_addr), .read_addr3(read_addr3), .read_data3(read_data3),
        .dbg_data(dbg_data)
    );

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
        exp_rf[a] = d;
    endtask

    // Applies one command to the model; returns expected err and expected write count.
    task automatic model_apply(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                               output logic e_err, output int e_we);
        int a, b, r;
        if (dst > 3 || src > 3) begin
            e_err = 1'b1;
            e_we = 0;
        end else begin
            e_err = 1'b0;
            e_we = (op == 3'd7) ? 0 : 1;
            a = int'(exp_rf[dst]);
            b = int'(exp_rf[src]);
            r = 0;
            case (op)
                3'd0: r = b;
                3'd1: begin r = a + b; m_cf = (r > 255); end
                3'd2, 3'd7: begin r = a - b; m_cf = (a < b); end
                3'd3: begin r = a & b; m_cf = 1'b0; end
                3'd4: begin r = a | b; m_cf = 1'b0; end
                3'd5: begin r = a ^ b; m_cf = 1'b0; end
                default: r = a + 1;
            endcase
            r = r & 255;
            m_result = 8'(r);
            if (op != 3'd0) begin
                m_zf = (r == 0);
                m_sf = (r >= 128);
            end
            if (op != 3'd7) exp_rf[dst] = 8'(r);
        end
    endtask

    // Call right after the accept edge; watches the command through to done and checks it.
    task automatic finish_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src);
        logic e_err;
        int   e_we, we_seen, done_at, lat;
        model_apply(op, dst, src, e_err, e_we);
        lat = e_err ? 1 : 4;
        we_seen = 0;
        done_at = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ready cyc %0d: got %b want 0", i, cmd_ready);
            end
            if (write_enable) begin
                we_seen++;
                n_checks++;
                if (write_addr !== dst) begin
                    n_fail++;
                    $display("FAIL write_addr: got %0d want %0d", write_addr, dst);
                end
            end
            if (done) begin
                done_at = i;
                break;
            end
        end
        n_checks++;
        if (done_at != lat) begin
            n_fail++;
            $display("FAIL done_latency op%0d: got %0d want %0d", op, done_at, lat);
        end
        n_checks++;
        if (err !== e_err) begin
            n_fail++;
            $display("FAIL err op%0d d%0d s%0d: got %b want %b", op, dst, src, err, e_err);
        end
        n_checks++;
        if (we_seen != e_we) begin
            n_fail++;
            $display("FAIL write_count op%0d: got %0d want %0d", op, we_seen, e_we);
        end
        n_checks++;
        if ({result, zf, cf, sf} !== {m_result, m_zf, m_cf, m_sf}) begin
            n_fail++;
            $display("FAIL result_flags op%0d: got %h z%b c%b s%b want %h z%b c%b s%b", op,
                     result, zf, cf, sf, m_result, m_zf, m_cf, m_sf);
        end
        n_checks++;
        if (rf[dst] !== exp_rf[dst]) begin
            n_fail++;
            $display("FAIL reg_value r%0d: got %h want %h", dst, rf[dst], exp_rf[dst]);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src);
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_dst = dst;
        cmd_src = src;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        // Scribble over the command bus while busy; it must be ignored.
        cmd_op = 3'($urandom_range(0, 7));
        cmd_dst = 3'($urandom_range(0, 7));
        cmd_src = 3'($urandom_range(0, 7));
        finish_cmd(op, dst, src);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_ready, done, err, write_enable} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rdy%b done%b err%b we%b want 1000",
                     cmd_ready, done, err, write_enable);
        end
        n_checks++;
        if ({result, zf, cf, sf, write_data} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_data: got res %h z%b c%b s%b wd %h want zeros",
                     result, zf, cf, sf, write_data);
        end
        n_checks++;
        if ({read_addr1, read_addr2, write_addr} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d %0d %0d want 0 0 0",
                     read_addr1, read_addr2, write_addr);
        end
        rst = 1'b0;
        for (int r = 0; r < 8; r++) preload(3'(r), 8'd0);
    endtask

    task automatic test_mov_add;
        preload(3'd0, 8'h01);
        preload(3'd1, 8'h04);
        preload(3'd2, 8'h05);
        run_cmd(3'd0, 3'd3, 3'd2);
        run_cmd(3'd1, 3'd0, 3'd1);
    endtask

    task automatic test_carry_borrow;
        preload(3'd0, 8'hF0);
        preload(3'd1, 8'h20);
        run_cmd(3'd1, 3'd0, 3'd1);
        run_cmd(3'd2, 3'd1, 3'd0);
    endtask

    task automatic test_cmp_inc;
        preload(3'd0, 8'h03);
        preload(3'd1, 8'h05);
        run_cmd(3'd7, 3'd0, 3'd1);
        preload(3'd2, 8'hFF);
        run_cmd(3'd6, 3'd2, 3'd2);
    endtask

    task automatic test_invalid;
        run_cmd(3'd1, 3'd4, 3'd0);
        run_cmd(3'd5, 3'd1, 3'd6);
    endtask

    task automatic test_reset_midop;
        preload(3'd0, 8'h11);
        preload(3'd1, 8'h22);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_dst = 3'd0;
        cmd_src = 3'd1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({cmd_ready, write_enable, done} !== 3'b100) begin
                n_fail++;
                $display("FAIL midop_reset: got rdy%b we%b done%b want 100",
                         cmd_ready, write_enable, done);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        m_result = 8'd0;
        m_zf = 1'b0;
        m_cf = 1'b0;
        m_sf = 1'b0;
        n_checks++;
        if (rf[0] !== 8'h11) begin
            n_fail++;
            $display("FAIL midop_dst: got %h want 11", rf[0]);
        end
        run_cmd(3'd1, 3'd0, 3'd1);
    endtask

    task automatic test_debug;
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 3'(a);
            #1;
            n_checks++;
            if (dbg_data !== exp_rf[a] || read_addr3 !== 3'(a)) begin
                n_fail++;
                $display("FAIL dbg_port a%0d: got %h@%0d want %h", a, dbg_data, read_addr3,
                         exp_rf[a]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic e_err;
        int   e_we;
        preload(3'd0, 8'h30);
        preload(3'd1, 8'h0C);
        preload(3'd2, 8'h5A);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        cmd_dst = 3'd0;
        cmd_src = 3'd1;
        @(posedge clk);
        #1;
        cmd_op = 3'd5;
        cmd_dst = 3'd2;
        cmd_src = 3'd2;
        model_apply(3'd1, 3'd0, 3'd1, e_err, e_we);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== (i == 5)) begin
                n_fail++;
                $display("FAIL b2b_ready cyc %0d: got %b want %b", i, cmd_ready, i == 5);
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n_checks++;
        if (rf[0] !== exp_rf[0]) begin
            n_fail++;
            $display("FAIL b2b_first: got %h want %h", rf[0], exp_rf[0]);
        end
        finish_cmd(3'd5, 3'd2, 3'd2);
    endtask

    task automatic test_random;
        logic [2:0] op, dst, src;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0)
                preload(3'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            op = 3'($urandom_range(0, 7));
            dst = 3'(($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3));
            src = 3'(($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3));
            run_cmd(op, dst, src);
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) exp_rf[r] = 8'd0;
        test_reset();
        test_mov_add();
        test_carry_borrow();
        test_cmp_inc();
        test_invalid();
        test_reset_midop();
        test_debug();
        test_back_to_back();
        test_random();
        test_debug();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
